clk_div_bank: RTL and testbench

//  Bank of NCH independent programmable clock dividers on one i_clk domain.

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_chan.sv | 62 ++++++
 rtl/clk_div_bank.sv | 55 +++++
 tb/tb_clk_div_bank.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
package clk_div_pkg;

  localparam int unsigned CLK_DIV_WIDTH_MAX = 32;
  localparam int unsigned CLK_DIV_NCH_MAX   = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Channel-select width; a single-channel bank still gets a 1-bit select.
  function automatic int unsigned chw_of(input int unsigned nch);
    return (nch > 1) ? clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, 50%-duty clock and toggle strobe.
module clk_div_chan #(
  parameter int unsigned       WIDTH   = 8,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_pend,
  output logic             o_clk,
  output logic             o_tick
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] shadow;
  logic             tc;
  logic             commit;

  always_comb begin
    tc     = (cnt == active);
    // Only a pend flag set before this edge commits; a coincident write waits.
    commit = o_pend && (!i_en || i_sync || tc);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      active <= RST_VAL;
      shadow <= RST_VAL;
      o_pend <= 1'b0;
      o_clk  <= 1'b0;
      o_tick <= 1'b0;
    end else begin
      if (!i_en || i_sync) begin
        cnt    <= '0;
        o_clk  <= 1'b0;
        o_tick <= 1'b0;
      end else if (tc) begin
        cnt    <= '0;
        o_clk  <= ~o_clk;
        o_tick <= 1'b1;
      end else begin
        cnt    <= cnt + WIDTH'(1);
        o_tick <= 1'b0;
      end

      if (commit) active <= shadow;

      if (i_wr) begin
        shadow <= i_div;
        o_pend <= 1'b1;
      end else if (commit) begin
        o_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH programmable clock dividers with glitch-free divisor updates.
// Define CLK_DIV_SYNC_EN to add the i_sync bank phase-realign input.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int unsigned NCH     = 4,
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned RST_DIV = 0,
  localparam int unsigned CHW     = chw_of(NCH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NCH-1:0]   i_en,
  input  logic             i_div_wr,
  input  logic [CHW-1:0]   i_div_ch,
  input  logic [WIDTH-1:0] i_div,
  output logic [NCH-1:0]   o_pend,
  output logic [NCH-1:0]   o_clk,
  output logic [NCH-1:0]   o_tick
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic             i_sync
`endif
);

  logic sync;

`ifdef CLK_DIV_SYNC_EN
  assign sync = i_sync;
`else
  assign sync = 1'b0;
`endif

  // Out-of-range channel numbers match no channel, so such writes are dropped.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic wr;
    assign wr = i_div_wr && (i_div_ch == CHW'(g));

    clk_div_chan #(
      .WIDTH   (WIDTH),
      .RST_VAL (WIDTH'(RST_DIV))
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en[g]),
      .i_sync  (sync),
      .i_wr    (wr),
      .i_div   (i_div),
      .o_pend  (o_pend[g]),
      .o_clk   (o_clk[g]),
      .o_tick  (o_tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: expected toggle events are queued and matched against o_tick.
module tb_clk_div_bank;

  localparam int NCH = 5;

  typedef struct {
    int   cyc;
    logic clk;
  } ev_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           div_wr;
  logic [2:0]     div_ch;
  logic [7:0]     div;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] dclk;
  logic [NCH-1:0] tick;
`ifdef CLK_DIV_SYNC_EN
  logic           sync;
`endif

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  watch_ch = 0;
  bit  watch_on = 1'b0;
  ev_t q[$];
  ev_t e_mon;

  clk_div_bank #(.NCH(NCH), .WIDTH(8), .RST_DIV(0)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (en),
    .i_div_wr (div_wr),
    .i_div_ch (div_ch),
    .i_div    (div),
    .o_pend   (pend),
    .o_clk    (dclk),
    .o_tick   (tick)
`ifdef CLK_DIV_SYNC_EN
    ,
    .i_sync   (sync)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every tick on the watched channel must match the next queued event.
  always @(negedge clk) begin
    if (watch_on && rst_n && tick[watch_ch]) begin
      if (q.size() == 0) begin
        check("tick_cyc", cyc, -1);
      end else begin
        e_mon = q.pop_front();
        check("tick_cyc", cyc, e_mon.cyc);
        check("tick_clk", int'(dclk[watch_ch]), int'(e_mon.clk));
      end
    end
  end

  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.clk = v;
    q.push_back(e);
  endtask

  task automatic start_watch(input int ch);
    q.delete();
    watch_ch = ch;
    watch_on = 1'b1;
  endtask

  task automatic finish_watch(input string tag, input int last);
    to_cyc(last);
    @(negedge clk);
    #1;
    check(tag, q.size(), 0);
    q.delete();
    watch_on = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_div(input int ch, input int v);
    div_wr = 1'b1;
    div_ch = 3'(ch);
    div    = 8'(v);
    to_cyc(cyc + 1);
    div_wr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    int t1;
    rst_n  = 1'b0;
    en     = '0;
    div_wr = 1'b0;
    div_ch = '0;
    div    = '0;
`ifdef CLK_DIV_SYNC_EN
    sync   = 1'b0;
`endif

    @(posedge clk);
    #1;
    check("rst_clk",  int'(dclk), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_pend", int'(pend), 0);
    to_cyc(cyc + 1);
    rst_n = 1'b1;
    to_cyc(cyc + 1);

    // ch0 with reset divisor 0: toggles every cycle, tick stays high
    t0 = cyc;
    en[0] = 1'b1;
    start_watch(0);
    for (int k = 1; k <= 8; k++) push(t0 + k, 1'(k % 2));
    finish_watch("t1_q", t0 + 8);
    check("t1_tick_hi", int'(tick[0]), 1);
    en[0] = 1'b0;

    // ch1 div=3 written while disabled, commits on the next edge
    wr_div(1, 3);
    check("t2_pend_set", int'(pend[1]), 1);
    to_cyc(cyc + 1);
    check("t2_pend_clr", int'(pend[1]), 0);
    t0 = cyc;
    en[1] = 1'b1;
    start_watch(1);
    push(t0 + 4, 1'b1);
    push(t0 + 8, 1'b0);
    push(t0 + 12, 1'b1);
    push(t0 + 16, 1'b0);
    finish_watch("t2_q", t0 + 16);
    en[1] = 1'b0;

    // ch2 at div=5, rewritten to 1 mid-period
    wr_div(2, 5);
    to_cyc(cyc + 1);
    t0 = cyc;
    en[2] = 1'b1;
    start_watch(2);
    push(t0 + 6, 1'b1);
    push(t0 + 12, 1'b0);
    push(t0 + 18, 1'b1);
    push(t0 + 20, 1'b0);
    push(t0 + 22, 1'b1);
    push(t0 + 24, 1'b0);
    to_cyc(t0 + 14);
    wr_div(2, 1);
    check("t3_pend_a", int'(pend[2]), 1);
    to_cyc(t0 + 17);
    check("t3_pend_b", int'(pend[2]), 1);
    to_cyc(t0 + 18);
    check("t3_pend_c", int'(pend[2]), 0);
    finish_watch("t3_q", t0 + 24);
    en[2] = 1'b0;

    // ch3 at div=2, write lands exactly on a terminal count
    wr_div(3, 2);
    to_cyc(cyc + 1);
    t0 = cyc;
    en[3] = 1'b1;
    start_watch(3);
    push(t0 + 3, 1'b1);
    push(t0 + 6, 1'b0);
    push(t0 + 9, 1'b1);
    push(t0 + 10, 1'b0);
    push(t0 + 11, 1'b1);
    push(t0 + 12, 1'b0);
    to_cyc(t0 + 5);
    wr_div(3, 0);
    check("t4_pend_a", int'(pend[3]), 1);
    to_cyc(t0 + 8);
    check("t4_pend_b", int'(pend[3]), 1);
    to_cyc(t0 + 9);
    check("t4_pend_c", int'(pend[3]), 0);
    finish_watch("t4_q", t0 + 12);
    en[3] = 1'b0;

    // out-of-range channel writes are ignored; ch1 keeps its period
    t0 = cyc;
    en[1] = 1'b1;
    start_watch(1);
    push(t0 + 4, 1'b1);
    push(t0 + 8, 1'b0);
    push(t0 + 12, 1'b1);
    push(t0 + 16, 1'b0);
    to_cyc(t0 + 2);
    wr_div(NCH, 7);
    wr_div(7, 0);
    check("t5_pend_a", int'(pend), 0);
    to_cyc(cyc + 1);
    check("t5_pend_b", int'(pend), 0);
    finish_watch("t5_q", t0 + 16);
    en[1] = 1'b0;
    to_cyc(cyc + 1);

    // reset mid-count with a pending write
    t0 = cyc;
    en[1] = 1'b1;
    en[2] = 1'b1;
    to_cyc(t0 + 1);
    wr_div(1, 9);
    check("t6_pre_pend", int'(pend[1]), 1);
    check("t6_pre_clk2", int'(dclk[2]), 1);
    check("t6_pre_tick2", int'(tick[2]), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_clk",  int'(dclk), 0);
    check("t6_rst_tick", int'(tick), 0);
    check("t6_rst_pend", int'(pend), 0);
    en = '0;
    to_cyc(cyc + 2);
    rst_n = 1'b1;
    to_cyc(cyc + 1);
    t1 = cyc;
    en[1] = 1'b1;
    start_watch(1);
    for (int k = 1; k <= 4; k++) push(t1 + k, 1'(k % 2));
    finish_watch("t6_q", t1 + 4);
    en[1] = 1'b0;
    to_cyc(cyc + 1);

`ifdef CLK_DIV_SYNC_EN
    // sync pulse restarts ch0 (div=2) and ch1 (div=5) from a common phase
    begin
      int e0;
      int s;
      wr_div(0, 2);
      wr_div(1, 5);
      to_cyc(cyc + 1);
      e0 = cyc;
      en[0] = 1'b1;
      to_cyc(e0 + 2);
      en[1] = 1'b1;
      to_cyc(e0 + 4);
      sync = 1'b1;
      to_cyc(e0 + 5);
      sync = 1'b0;
      s = cyc;
      check("ts_clk_zero", int'(dclk[1:0]), 0);
      start_watch(0);
      push(s + 3, 1'b1);
      push(s + 6, 1'b0);
      to_cyc(s + 5);
      check("ts_ch1_low", int'(dclk[1]), 0);
      to_cyc(s + 6);
      check("ts_ch1_rise", int'(dclk[1]), 1);
      check("ts_ch0_fall", int'(dclk[0]), 0);
      finish_watch("ts_q", s + 6);
      en = '0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
